pwm_peripheral: RTL and testbench

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_peripheral.sv | 90 +++++++++
 tb/tb_pwm_peripheral.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-output PWM peripheral with prescaled 8-bit counter
// Optional duty shadow register enabled by defining PWM_DUTY_SHADOW_EN.
module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] r_presc;
    logic [7:0]    r_pwm_count;
    logic [15:0]   r_out;
    logic          r_period_start;

    logic          w_tick;
    logic          w_wrap;
    logic [7:0]    w_duty;
    logic          w_level;
    logic [15:0]   w_en_out;
    logic [15:0]   w_en_pwm;
    logic [15:0]   w_next_out;

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_wrap = w_tick && (r_pwm_count == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_count <= 8'h00;
        end else if (w_tick) begin
            r_pwm_count <= r_pwm_count + 8'h01;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] r_duty_shadow;

    // Duty is captured only at the period boundary so a period never mixes two duties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= 8'h00;
        end else if (w_wrap) begin
            r_duty_shadow <= pwm_duty_cycle;
        end
    end

    assign w_duty = r_duty_shadow;
`else
    assign w_duty = pwm_duty_cycle;
`endif

    // 0xFF forces a full-on level; 0x00 never matches the compare, so no boundary glitch.
    assign w_level    = (w_duty == 8'hFF) || (r_pwm_count < w_duty);
    assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_next_out = w_en_out & (~w_en_pwm | {16{w_level}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out          <= 16'h0000;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_next_out;
            r_period_start <= w_wrap;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - scoreboard bench for pwm_peripheral against a time-based model
module tb_pwm_peripheral;

    localparam int P   = 2;
    localparam int PER = 256 * P;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out;
    logic        ps;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (ps)
    );

    typedef struct packed {
        logic [15:0] o;
        logic        p;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   k        = 0;
`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] m_shadow = 8'h00;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    // Model: k counts clk edges since reset release; counter value is (k/P) mod 256.
    task automatic push_expect();
        exp_t       e;
        int         cnt;
        logic [7:0] eff;
        logic       lvl;
        if (!rst_n) begin
            e.o = 16'h0;
            e.p = 1'b0;
            k   = 0;
`ifdef PWM_DUTY_SHADOW_EN
            m_shadow = 8'h00;
`endif
        end else begin
            cnt = (k / P) % 256;
`ifdef PWM_DUTY_SHADOW_EN
            eff = m_shadow;
`else
            eff = duty;
`endif
            lvl = (eff == 8'hFF) || (cnt < int'(eff));
            e.o = en_out & (~en_pwm | (lvl ? 16'hFFFF : 16'h0000));
            k++;
            e.p = ((k % PER) == 0);
`ifdef PWM_DUTY_SHADOW_EN
            if (e.p) m_shadow = duty;
`endif
        end
        sbq.push_back(e);
    endtask

    task automatic step();
        push_expect();
        @(negedge clk);
    endtask

    task automatic mid_reset();
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 32'(out), 32'h0);
        check("async_reset_ps", 32'(ps), 32'h0);
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("out", 32'(out), 32'(mon_e.o));
            check("period_start", 32'(ps), 32'(mon_e.p));
        end
    end

    initial begin
        int hi;
        int guard;
        int rst_at;
        rst_n  = 1'b0;
        en_out = 16'h0;
        en_pwm = 16'h0;
        duty   = 8'h00;
        @(negedge clk);
        check("reset_out", 32'(out), 32'h0);
        check("reset_ps", 32'(ps), 32'h0);
        repeat (3) step();
        rst_n = 1'b1;

        en_out = 16'h00FF;
        repeat (20) step();
        en_out = 16'h0000;
        repeat (10) step();

        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'h80;
        repeat (PER + 10) step();

        duty = 8'h00;
        repeat (3 * PER) step();
        duty = 8'hFF;
        repeat (3 * PER) step();

        en_pwm = 16'h0001;
        en_out = 16'h0003;
        duty   = 8'h40;
        repeat (PER + 4) step();
        hi = 0;
        for (int i = 0; i < PER; i++) begin
            if (out[0]) hi++;
            step();
        end
        check("duty40_high_clks", 32'(hi), 32'd128);

        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        step();
        guard = 0;
        while (((k / P) % 256) != 32'h20 && guard < 2 * PER) begin
            step();
            guard++;
        end
        check("reach_count_20", 32'((k / P) % 256), 32'h20);
        duty = 8'hC0;
        repeat (2 * PER) step();

        rst_at = $urandom_range(PER / 2, 3 * PER);
        for (int i = 0; i < 4 * PER; i++) begin
            if ($urandom_range(0, 99) < 2) en_out = 16'($urandom);
            if ($urandom_range(0, 99) < 2) en_pwm = 16'($urandom);
            if ($urandom_range(0, 99) < 2) begin
                case ($urandom_range(0, 3))
                    0:       duty = 8'h00;
                    1:       duty = 8'hFF;
                    default: duty = 8'($urandom);
                endcase
            end
            if (i == rst_at) mid_reset();
            step();
        end

        @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
